// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter that shares one external DMA word engine among the endpoint
// DMA channels, with bounded bursts and a two-cycle settle gap after every word.
module usbf_dma_arb #(
  parameter int NEP       = 4,
  parameter int BURST_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NEP-1:0] dma_req,
  output logic [NEP-1:0] dma_ack,
  output logic           ch_req,
  output logic [1:0]     ch_sel,
  input  logic           ch_ack,
  output logic           busy,
  output logic [1:0]     state_dbg
);

  // Handshake: ch_req stays high through XFER until the engine answers with a
  // one-cycle ch_ack; each accepted word produces one dma_ack pulse on the next cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] grant;
  logic [1:0] last;
  logic [7:0] beat_cnt;
  logic       settle_cnt;
  logic [1:0] rr_win;
  logic [1:0] rr_cand;
  logic       rr_found;
  logic [7:0] beat_inc;
  logic       burst_open;

  assign state_dbg  = state;
  assign burst_open = beat_cnt < 8'(BURST_MAX);
  assign beat_inc   = burst_open ? beat_cnt + 8'd1 : beat_cnt;

  // Search starts just after the previous winner; 2-bit wrap gives mod-4 order.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = last;
    rr_cand  = '0;
    for (int k = 1; k <= NEP; k++) begin
      rr_cand = last + 2'(k);
      if (!rr_found && dma_req[rr_cand]) begin
        rr_found = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch_req     <= 1'b0;
      ch_sel     <= 2'd0;
      dma_ack    <= '0;
      busy       <= 1'b0;
      grant      <= 2'd0;
      last       <= 2'd3;
      beat_cnt   <= 8'd0;
      settle_cnt <= 1'b0;
    end else begin
      dma_ack <= '0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant    <= rr_win;
            last     <= rr_win;
            ch_sel   <= rr_win;
            beat_cnt <= 8'd0;
            ch_req   <= 1'b1;
            busy     <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
          if (ch_ack) begin
            beat_cnt   <= beat_inc;
            dma_ack    <= NEP'(1) << grant;
            ch_req     <= 1'b0;
            settle_cnt <= 1'b0;
            state      <= SETTLE;
          end else if (!dma_req[grant]) begin
            ch_req <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        SETTLE: begin
          if (!settle_cnt) begin
            settle_cnt <= 1'b1;
          end else if (dma_req[grant] && burst_open) begin
            ch_req <= 1'b1;
            state  <= XFER;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          ch_req <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Directed bench for usbf_dma_arb: a word-level arbitration model checked every
// cycle, an expected-ack queue for burst ordering, and literal spot checks.
module tb_usbf_dma_arb;

  localparam int BM = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dma_req;
  logic [3:0] dma_ack;
  logic       ch_req;
  logic [1:0] ch_sel;
  logic       ch_ack;
  logic       busy;
  logic [1:0] state_dbg;

  logic auto_ack, stray_ack, sb_on;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_q[$];

  usbf_dma_arb #(.NEP(4), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .dma_req(dma_req), .dma_ack(dma_ack),
    .ch_req(ch_req), .ch_sel(ch_sel), .ch_ack(ch_ack), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Engine stand-in: answers a pending ch_req right after the edge that raised it.
  initial ch_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    ch_ack = (auto_ack && ch_req) || stray_ack;
  end

  // ---------------- behavioural model ----------------
  int         m_owner, m_last, m_words, m_settle_left;
  bit         m_xfer;
  logic [1:0] m_sel;
  logic [3:0] m_ack;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_last = 3; m_words = 0; m_settle_left = 0;
      m_xfer = 0; m_sel = 2'd0; m_ack = 4'd0;
    end else begin
      m_ack = 4'd0;
      if (m_xfer) begin
        if (ch_ack) begin
          if (m_words < BM) m_words = m_words + 1;
          m_ack = 4'(1 << m_owner);
          m_xfer = 0;
          m_settle_left = 2;
        end else if (!dma_req[m_owner]) begin
          m_xfer = 0;
        end
      end else if (m_settle_left > 0) begin
        m_settle_left = m_settle_left - 1;
        if (m_settle_left == 0 && dma_req[m_owner] && m_words < BM) m_xfer = 1;
      end else if (dma_req != 4'd0) begin
        for (int k = 1; k <= 4; k++) begin
          if (!m_xfer && dma_req[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            m_xfer = 1;
          end
        end
        m_last  = m_owner;
        m_words = 0;
        m_sel   = 2'(m_owner);
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    logic exp_busy;
    logic [3:0] e;
    exp_busy = m_xfer || (m_settle_left > 0);
    checks = checks + 4;
    if (ch_req !== m_xfer) begin
      errors++; $display("FAIL model_ch_req t=%0t got %b expected %b", $time, ch_req, m_xfer);
    end
    if (ch_sel !== m_sel) begin
      errors++; $display("FAIL model_ch_sel t=%0t got %0d expected %0d", $time, ch_sel, m_sel);
    end
    if (dma_ack !== m_ack) begin
      errors++; $display("FAIL model_dma_ack t=%0t got %b expected %b", $time, dma_ack, m_ack);
    end
    if (busy !== exp_busy) begin
      errors++; $display("FAIL model_busy t=%0t got %b expected %b", $time, busy, exp_busy);
    end
    if (sb_on && dma_ack != 4'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_extra_ack t=%0t got %b expected none", $time, dma_ack);
      end else begin
        e = exp_q.pop_front();
        if (dma_ack !== e) begin
          errors++; $display("FAIL sb_ack_order t=%0t got %b expected %b", $time, dma_ack, e);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (ch_req !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    chk("wait_ch_req", 32'(ch_req), 1);
  endtask

  task automatic wait_ack(input logic [3:0] mask, input int budget);
    int n = 0;
    while (dma_ack !== mask && n < budget) begin @(negedge clk); n++; end
    chk("wait_dma_ack", 32'(dma_ack), 32'(mask));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    chk("wait_idle", 32'(busy), 0);
  endtask

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    chk("sb_queue_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    auto_ack = 1'b0;
    dma_req  = 4'd0;
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_acks(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mask);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic [3:0] seen;
    rst = 1'b1; dma_req = 4'd0; auto_ack = 1'b0; stray_ack = 1'b0; sb_on = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ch_req", 32'(ch_req), 0);
    chk("reset_ch_sel", 32'(ch_sel), 0);
    chk("reset_dma_ack", 32'(dma_ack), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_state", 32'(state_dbg), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Stray ch_ack while idle is ignored
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    chk("stray_busy", 32'(busy), 0);
    chk("stray_dma_ack", 32'(dma_ack), 0);
    repeat (2) @(negedge clk);

    // Single request on ep2
    dma_req = 4'b0100; auto_ack = 1'b1;
    wait_req(10);
    chk("single_ch_sel", 32'(ch_sel), 2);
    @(negedge clk);
    chk("single_dma_ack", 32'(dma_ack), 32'h4);
    chk("single_settle1_req", 32'(ch_req), 0);
    @(negedge clk);
    chk("single_settle2_ack", 32'(dma_ack), 0);
    chk("single_settle2_req", 32'(ch_req), 0);
    chk("single_settle2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("single_rereq", 32'(ch_req), 1);
    dma_req = 4'd0;
    wait_idle(20);

    // Burst limit with ep0 and ep1 both requesting
    do_reset();
    push_acks(4'b0001, BM); push_acks(4'b0010, BM); push_acks(4'b0001, BM);
    sb_on = 1'b1; dma_req = 4'b0011; auto_ack = 1'b1;
    wait_q_empty(400);
    sb_on = 1'b0; dma_req = 4'd0;
    wait_idle(20);

    // Round-robin wrap between ep0 and ep3
    do_reset();
    push_acks(4'b0001, BM); push_acks(4'b1000, BM); push_acks(4'b0001, 1);
    sb_on = 1'b1; dma_req = 4'b1001; auto_ack = 1'b1;
    wait_q_empty(400);
    sb_on = 1'b0; dma_req = 4'd0;
    wait_idle(20);

    // Endpoint release right after its acknowledge
    do_reset();
    dma_req = 4'b0010; auto_ack = 1'b1;
    wait_ack(4'b0010, 10);
    @(posedge clk);
    #1 dma_req = 4'd0;
    @(negedge clk);
    chk("release_settle2_busy", 32'(busy), 1);
    @(negedge clk);
    chk("release_idle_busy", 32'(busy), 0);
    cnt = 0;
    repeat (10) begin @(negedge clk); if (ch_req) cnt++; end
    chk("release_no_req", 32'(cnt), 0);

    // Abort without ch_ack
    do_reset();
    dma_req = 4'b0001;
    wait_req(10);
    dma_req = 4'd0;
    @(negedge clk);
    chk("abort_ch_req", 32'(ch_req), 0);
    chk("abort_busy", 32'(busy), 0);
    seen = dma_ack;
    repeat (3) begin @(negedge clk); seen = seen | dma_ack; end
    chk("abort_no_ack", 32'(seen), 0);

    // Request drop coincident with ch_ack: word still acknowledged
    auto_ack = 1'b1; dma_req = 4'b0001;
    wait_req(10);
    dma_req = 4'd0;
    @(negedge clk);
    chk("simul_dma_ack", 32'(dma_ack), 32'h1);
    chk("simul_ch_req", 32'(ch_req), 0);
    wait_idle(10);

    // Reset during the first settle cycle
    dma_req = 4'b0100;
    wait_ack(4'b0100, 10);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ch_req", 32'(ch_req), 0);
    chk("midrst_dma_ack", 32'(dma_ack), 0);
    chk("midrst_busy", 32'(busy), 0);
    dma_req = 4'b1111;
    @(negedge clk);
    #2 rst = 1'b0;
    wait_req(10);
    chk("midrst_first_grant", 32'(ch_sel), 0);
    dma_req = 4'd0; auto_ack = 1'b0;
    wait_idle(20);
    seen = 4'd0;
    repeat (4) begin @(negedge clk); seen = seen | dma_ack; end
    chk("midrst_no_late_ack", 32'(seen), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
